// File: rtl/mul_div_unit.sv
// mul_div_unit: RISC-V M-extension multiply/divide unit with ready/valid handshake.
// Multiplies in a two-stage pipeline (product, then sign fix/select); divides with a
// restoring radix-2 iterative divider that takes one quotient bit per cycle.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_in,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic                  ready,
  output logic                  enable_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero,
  output logic                  ov
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_MUL = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    MUL_PIPE,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_t;

  state_t state, next_state;

  // Captured operation and working registers
  logic [2:0]    op_q;
  logic [W-1:0]  a_q;      // multiplicand magnitude, or dividend shifting into quotient
  logic [W-1:0]  b_q;      // multiplier / divisor magnitude
  logic [W-1:0]  r_q;      // partial remainder
  logic [PW-1:0] p_q;      // unsigned product of magnitudes
  logic          neg_q;    // negate product / quotient
  logic          rneg_q;   // negate remainder (dividend sign)
  logic          dz_q;
  logic          ov_q;
  logic          stage_q;  // second multiply pipeline cycle
  logic [CW-1:0] cnt_q;

  // Operand decode on the live inputs, used only at acceptance
  logic          x_signed, y_signed, x_neg, y_neg;
  logic [W-1:0]  x_mag, y_mag;
  logic          div_zero_in, div_ov_in, accept;

  always_comb begin
    x_signed    = !(op == 3'b011 || op == 3'b101 || op == 3'b111);
    y_signed    = (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
    x_neg       = x_signed & x[W-1];
    y_neg       = y_signed & y[W-1];
    x_mag       = x_neg ? -x : x;
    y_mag       = y_neg ? -y : y;
    div_zero_in = op[2] && (y == '0);
    div_ov_in   = op[2] && !op[0] && (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);
    accept      = enable_in & ready;
  end

  // Restoring-division step and final sign fix / result selection
  logic [W:0]    shifted, diff;
  logic [PW-1:0] p_fix;
  logic [W-1:0]  q_fix, r_fix, result_d;
  logic          load_result;

  always_comb begin
    shifted     = {r_q, a_q[W-1]};
    diff        = shifted - {1'b0, b_q};
    p_fix       = neg_q ? -p_q : p_q;
    q_fix       = neg_q ? -a_q : a_q;
    r_fix       = rneg_q ? -r_q : r_q;
    if (op_q[2])
      result_d = op_q[1] ? r_fix : q_fix;
    else
      result_d = (op_q == OP_MUL) ? p_fix[W-1:0] : p_fix[PW-1:W];
    load_result = (state == MUL_PIPE && stage_q) || (state == DIV_FIX);
  end

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    enable_out = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready      = 1'b1;
        enable_out = (state == DONE);
        if (enable_in) begin
          if (!op[2])                        next_state = MUL_PIPE;
          else if (div_zero_in || div_ov_in) next_state = DIV_FIX;
          else                               next_state = DIV_ITER;
        end else begin
          next_state = IDLE;
        end
      end
      MUL_PIPE: if (stage_q) next_state = DONE;
      DIV_ITER: if (cnt_q == CW'(1)) next_state = DIV_FIX;
      DIV_FIX:  next_state = DONE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: capture at acceptance, then multiply or iterate
  // NOTE: working registers carry no reset; the FSM never reads them before acceptance loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      a_q     <= x_mag;
      b_q     <= y_mag;
      r_q     <= '0;
      neg_q   <= x_neg ^ y_neg;
      rneg_q  <= x_neg;
      dz_q    <= div_zero_in;
      ov_q    <= div_ov_in;
      stage_q <= 1'b0;
      cnt_q   <= CW'(W);
      if (div_zero_in) begin
        a_q    <= '1;
        r_q    <= x;
        neg_q  <= 1'b0;
        rneg_q <= 1'b0;
      end else if (div_ov_in) begin
        a_q    <= x;
        r_q    <= '0;
        neg_q  <= 1'b0;
        rneg_q <= 1'b0;
      end
    end else begin
      case (state)
        MUL_PIPE: begin
          if (!stage_q) p_q <= PW'(a_q) * PW'(b_q);
          stage_q <= 1'b1;
        end
        DIV_ITER: begin
          r_q   <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
          a_q   <= {a_q[W-2:0], ~diff[W]};
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result and flag registers, updated only when entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      ov          <= 1'b0;
    end else if (load_result) begin
      result      <= result_d;
      div_by_zero <= op_q[2] & dz_q;
      ov          <= op_q[2] & ov_q;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (32-bit and 16-bit instances).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_in;
  logic [2:0]  op;
  logic [31:0] x, y;
  logic        ready, enable_out, div_by_zero, ov;
  logic [31:0] result;

  logic        enable_in16;
  logic [2:0]  op16;
  logic [15:0] x16, y16;
  logic        ready16, enable_out16, div_by_zero16, ov16;
  logic [15:0] result16;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        dz, ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        dz, ovf;
    int          lat;
  } vec16_t;

  mul_div_unit #(.DATA_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .op(op), .x(x), .y(y),
    .ready(ready), .enable_out(enable_out), .result(result),
    .div_by_zero(div_by_zero), .ov(ov)
  );

  mul_div_unit #(.DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable_in(enable_in16), .op(op16), .x(x16), .y(y16),
    .ready(ready16), .enable_out(enable_out16), .result(result16),
    .div_by_zero(div_by_zero16), .ov(ov16)
  );

  always #5 clk = ~clk;

  // Issue one op in cycle 0, return outputs at the enable_out cycle and its cycle number.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                        output logic [31:0] res, output logic dz, ovf, output int lat);
    @(negedge clk);
    op = o; x = a; y = b; enable_in = 1'b1;
    @(negedge clk);
    enable_in = 1'b0;
    lat = 1;
    while (enable_out !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result; dz = div_by_zero; ovf = ov;
  endtask

  task automatic run_op16(input logic [2:0] o, input logic [15:0] a, b,
                          output logic [15:0] res, output logic dz, ovf, output int lat);
    @(negedge clk);
    op16 = o; x16 = a; y16 = b; enable_in16 = 1'b1;
    @(negedge clk);
    enable_in16 = 1'b0;
    lat = 1;
    while (enable_out16 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result16; dz = div_by_zero16; ovf = ov16;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1; enable_in = 1'b0; enable_in16 = 1'b0;
    op = '0; x = '0; y = '0; op16 = '0; x16 = '0; y16 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, enable_out, div_by_zero, ov} !== 4'b1000)
      $display("FAIL reset_ctrl: got ready/en/dz/ov=%b, want 1000", {ready, enable_out, div_by_zero, ov});
    else passed++;
    total++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h, want 00000000", result);
    else passed++;
    // reset wins over a simultaneous enable_in
    reset = 1'b1; enable_in = 1'b1; op = 3'b000; x = 32'd3; y = 32'd5;
    @(negedge clk);
    reset = 1'b0; enable_in = 1'b0;
    total++;
    if (ready !== 1'b1) $display("FAIL reset_priority_ready: got %b, want 1", ready);
    else passed++;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (enable_out === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL reset_priority_pulse: got %0d pulses, want 0", pulses);
    else passed++;
  endtask

  task automatic test_mul();
    vec_t v[6];
    logic [31:0] r; logic d, o; int l;
    v = '{'{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 3},
          '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 3},
          '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 3},
          '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 1'b0, 3},
          '{3'b000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFF9, 1'b0, 1'b0, 3},
          '{3'b001, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b0, 3}};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, d, o, l);
      total++;
      if ({r, d, o} !== {v[i].res, v[i].dz, v[i].ovf})
        $display("FAIL mul[%0d] op=%b: got res=%h dz=%b ov=%b, want res=%h dz=%b ov=%b",
                 i, v[i].op, r, d, o, v[i].res, v[i].dz, v[i].ovf);
      else passed++;
      total++;
      if (l != v[i].lat) $display("FAIL mul_latency[%0d]: got %0d, want %0d", i, l, v[i].lat);
      else passed++;
    end
  endtask

  task automatic test_div();
    vec_t v[4];
    logic [31:0] r; logic d, o; int l;
    v = '{'{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 34},
          '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 34},
          '{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, 1'b0, 34},
          '{3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 34}};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, d, o, l);
      total++;
      if ({r, d, o} !== {v[i].res, v[i].dz, v[i].ovf})
        $display("FAIL div[%0d] op=%b: got res=%h dz=%b ov=%b, want res=%h dz=%b ov=%b",
                 i, v[i].op, r, d, o, v[i].res, v[i].dz, v[i].ovf);
      else passed++;
      total++;
      if (l != v[i].lat) $display("FAIL div_latency[%0d]: got %0d, want %0d", i, l, v[i].lat);
      else passed++;
    end
  endtask

  task automatic test_special();
    vec_t v[8];
    logic [31:0] r; logic d, o; int l;
    v = '{'{3'b100, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 2},
          '{3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 2},
          '{3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 2},
          '{3'b111, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 2},
          '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 2},
          '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 2},
          '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 34},
          '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 34}};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, d, o, l);
      total++;
      if ({r, d, o} !== {v[i].res, v[i].dz, v[i].ovf})
        $display("FAIL special[%0d] op=%b: got res=%h dz=%b ov=%b, want res=%h dz=%b ov=%b",
                 i, v[i].op, r, d, o, v[i].res, v[i].dz, v[i].ovf);
      else passed++;
      total++;
      if (l != v[i].lat) $display("FAIL special_latency[%0d]: got %0d, want %0d", i, l, v[i].lat);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses, first_cyc, second_cyc;
    logic [31:0] first_res, second_res;
    logic ready_busy, ready_at_done;
    pulses = 0; first_cyc = -1; second_cyc = -1;
    first_res = 'x; second_res = 'x; ready_busy = 'x; ready_at_done = 'x;
    @(negedge clk);
    op = 3'b101; x = 32'd1000; y = 32'd10; enable_in = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      enable_in = 1'b0;
      if (cyc == 1) ready_busy = ready;
      if (cyc == 5 || cyc == 20) begin
        op = 3'b000; x = 32'd9; y = 32'd9; enable_in = 1'b1;
      end
      if (enable_out === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first_cyc = cyc; first_res = result; ready_at_done = ready;
          op = 3'b000; x = 32'd3; y = 32'd5; enable_in = 1'b1;
        end else if (pulses == 2) begin
          second_cyc = cyc; second_res = result;
        end
      end
    end
    total++;
    if (ready_busy !== 1'b0) $display("FAIL busy_ready: got %b, want 0", ready_busy);
    else passed++;
    total++;
    if (pulses != 2) $display("FAIL pulse_count: got %0d, want 2", pulses);
    else passed++;
    total++;
    if (first_cyc != 34 || first_res !== 32'd100)
      $display("FAIL divu_handshake: got cycle %0d res=%h, want cycle 34 res=%h", first_cyc, first_res, 32'd100);
    else passed++;
    total++;
    if (ready_at_done !== 1'b1) $display("FAIL ready_at_done: got %b, want 1", ready_at_done);
    else passed++;
    total++;
    if (second_cyc != 37 || second_res !== 32'd15)
      $display("FAIL back_to_back_mul: got cycle %0d res=%h, want cycle 37 res=%h", second_cyc, second_res, 32'd15);
    else passed++;
  endtask

  task automatic test_reset_midop();
    int pulses;
    logic [31:0] r; logic d, o; int l;
    pulses = 0;
    @(negedge clk);
    op = 3'b100; x = 32'd100; y = 32'd7; enable_in = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      enable_in = 1'b0;
      if (enable_out === 1'b1) pulses++;
      if (cyc == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({ready, result, div_by_zero, ov} !== {1'b1, 32'h0, 2'b00})
      $display("FAIL midop_reset_state: got ready=%b res=%h dz=%b ov=%b, want ready=1 res=00000000 dz=0 ov=0",
               ready, result, div_by_zero, ov);
    else passed++;
    repeat (50) begin
      @(negedge clk);
      if (enable_out === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL midop_no_pulse: got %0d pulses, want 0", pulses);
    else passed++;
    run_op(3'b100, 32'd100, 32'd7, r, d, o, l);
    total++;
    if (r !== 32'd14 || l != 34) $display("FAIL post_reset_div: got res=%h lat=%0d, want res=%h lat=34", r, l, 32'd14);
    else passed++;
    run_op(3'b110, 32'd100, 32'd7, r, d, o, l);
    total++;
    if (r !== 32'd2 || l != 34) $display("FAIL post_reset_rem: got res=%h lat=%0d, want res=%h lat=34", r, l, 32'd2);
    else passed++;
  endtask

  task automatic test_width16();
    vec16_t v[5];
    logic [15:0] r; logic d, o; int l;
    v = '{'{3'b001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 3},
          '{3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 3},
          '{3'b100, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 2},
          '{3'b100, 16'h8000, 16'h0003, 16'hD556, 1'b0, 1'b0, 18},
          '{3'b110, 16'h8000, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 18}};
    foreach (v[i]) begin
      run_op16(v[i].op, v[i].a, v[i].b, r, d, o, l);
      total++;
      if ({r, d, o} !== {v[i].res, v[i].dz, v[i].ovf})
        $display("FAIL w16[%0d] op=%b: got res=%h dz=%b ov=%b, want res=%h dz=%b ov=%b",
                 i, v[i].op, r, d, o, v[i].res, v[i].dz, v[i].ovf);
      else passed++;
      total++;
      if (l != v[i].lat) $display("FAIL w16_latency[%0d]: got %0d, want %0d", i, l, v[i].lat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_midop();
    test_width16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised integer multiply/divide unit implementing the full RISC-V M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable data width. It sits beside the ALU in the execute stage. It is the successor of the fixed 32-bit multiply/divide block, and adds:
- a single-result op-encoded interface;
- a ready/busy handshake;
- architecturally defined divide-by-zero and signed-overflow results;
- a built-in radix-2 iterative divider.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width (even, >= 8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- enable_in  in  1  start request; accepted only on a cycle where ready=1.
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- x  in  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- y  in  DATA_WIDTH  rs2 operand (divisor / multiplier).
- ready  out  1  unit idle, can accept enable_in; reset value 1.
- enable_out  out  1  one-cycle result-valid pulse; reset value 0.
- result  out  DATA_WIDTH  result; held until the next enable_out; reset value 0.
- div_by_zero  out  1  valid with enable_out; divide op with y=0; reset value 0.
- ov  out  1  valid with enable_out; DIV/REM with x=most-negative and y=-1; reset value 0.

## Operation
- States: IDLE, MUL_PIPE, DIV_ITER, DIV_FIX, DONE.
- Acceptance: enable_in & ready captures op, x, y, operand signs and the abs/raw selection, then leaves IDLE. enable_in while ready=0 is ignored; there is no queueing.

Signedness:
- x is signed for MUL, MULH, MULHSU, DIV, REM.
- y is signed for MUL, MULH, DIV, REM.

Multiply:
- W×W unsigned product of the magnitudes, 2W bits wide.
- The product is negated when exactly one signed operand is negative.
- MUL returns the low W bits; the other multiply ops return the high W bits.
- MUL_PIPE: capture → product register → sign-fix/select → DONE.

Divide:
- Restoring radix-2 division on the magnitudes.
- DIV_ITER runs exactly DATA_WIDTH iterations under a down-counter.
- DIV_FIX applies the signs: the quotient is negated when the signed operand signs differ; the remainder takes the dividend's sign.

Special cases are detected at acceptance; they skip DIV_ITER and go straight to DIV_FIX:
- y=0: quotient = all ones, remainder = x, div_by_zero=1.
- Signed overflow (x=100…0, y=all ones, signed op): quotient = x, remainder = 0, ov=1.
- div_by_zero and ov are 0 for all multiply ops and unsigned overflow cases.

DONE:
- Registers result, pulses enable_out for one cycle, and returns to IDLE with ready=1.

Reset:
- Reset during any state forces IDLE.
- After the reset edge, ready=1, enable_out=0, result=0, and both flags are 0.
- An in-flight operation is discarded and produces no enable_out.
- Reset has priority over a simultaneous enable_in.

## Timing
- Cycle 0 is the cycle in which enable_in & ready is sampled.
- ready drops in cycle 1 and stays low until enable_out.
- Multiply: enable_out in cycle 3, for every DATA_WIDTH.
- Divide (normal): enable_out in cycle DATA_WIDTH+2, i.e. cycle 34 for DATA_WIDTH=32.
- Divide (zero or overflow): enable_out in cycle 2.
- ready returns to 1 in the enable_out cycle, so a new enable_in in that same cycle is accepted (back-to-back issue).
- result and the flags change only on enable_out cycles.
- Inputs need to be stable only in cycle 0.

## Test plan
- MUL/MULH/MULHU/MULHSU, W=32, x=0x80000000, y=0x80000000 → MUL 0x00000000, MULH 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000; enable_out in cycle 3; flags 0.
- DIV/REM x=-7 (0xFFFFFFF9), y=2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC, REMU → 1; enable_out in cycle 34.
- y=0 with x=0x12345678 → DIV/DIVU 0xFFFFFFFF, REM/REMU 0x12345678, div_by_zero=1, enable_out in cycle 2. x=0x80000000, y=0xFFFFFFFF → DIV 0x80000000, ov=1, REM 0, ov=1; DIVU 0, REMU 0x80000000, ov=0.
- Handshake: DIVU accepted, enable_in pulsed in cycles 5 and 20 with other operands → ignored, single enable_out. Then enable_in in that enable_out cycle with MUL 3×5 → result 15 three cycles later.
- Reset asserted in cycle 10 of a DIV → no enable_out ever; ready=1 and result=0 after reset. A subsequent DIV 100/7 → 14, and REM → 2.
- DATA_WIDTH=16 instance: MULH 0xFFFF×0xFFFF → 0x0000, MULHU → 0xFFFE, DIV 0x8000/0xFFFF → 0x8000 with ov=1; normal DIV latency 18 cycles.
